uart_mem_loader: RTL

- Sits directly downstream of the debug unit's programming path.
- Consumes the per-word write stream (address, data, one-cycle write strobe) and the end-of-program pulse.
- Buffers words in a small FIFO and routes each word to instruction memory or data memory by address.
- Holds the CPU until every word is written, then pulses a completion flag; also reports a word count, a checksum and sticky error flags.

---
 rtl/uart_mem_loader_pkg.sv | 15 +
 rtl/uart_mem_loader_sync_fifo.sv | 45 ++++
 rtl/uart_mem_loader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_mem_loader_pkg.sv
// Shared constants for the UART program loader: loader states, memory split and word width.
package uart_mem_loader_pkg;

  localparam int unsigned IsaWidth      = 32;
  localparam int unsigned ImemWordsDflt = 16384;
  localparam int unsigned DmemWordsDflt = 16384;

  typedef enum logic [1:0] {
    LdIdle  = 2'd0,
    LdLoad  = 2'd1,
    LdDrain = 2'd2,
    LdDone  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/uart_mem_loader_sync_fifo.sv
// Small synchronous FIFO; a push while full is accepted only when a pop happens in the same cycle.
module uart_mem_loader_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Buffers the debug unit's word stream and writes it into instruction or data memory,
// holding the CPU until the program is fully written.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = IsaWidth,
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned IMEM_WORDS = ImemWordsDflt,
  parameter int unsigned DMEM_WORDS = DmemWordsDflt,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_done,
  input  logic                  mem_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  overflow_err,
  output logic                  range_err
);

  localparam int unsigned EntryW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0]   ImemLimit = (ADDR_WIDTH+1)'(IMEM_WORDS);
  localparam logic [ADDR_WIDTH:0]   DmemLimit = (ADDR_WIDTH+1)'(IMEM_WORDS + DMEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] DmemBase  = ADDR_WIDTH'(IMEM_WORDS);
  localparam logic [ADDR_WIDTH:0]   CountOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  loader_state_e state_q, state_d;

  logic                  imem_we_q, dmem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q, dmem_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  ovf_q, rng_q;

  logic                  fifo_full, fifo_empty, pop, drop, strobe;
  logic                  start_load, empty_load;
  logic [EntryW-1:0]     head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_imem, head_dmem;

  uart_mem_loader_sync_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (in_valid),
    .wdata_i ({in_addr, in_data}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop       = !fifo_empty && mem_ready;
  assign drop      = in_valid && fifo_full && !pop;
  assign strobe    = imem_we_q || dmem_we_q;
  assign head_addr = head[DATA_WIDTH +: ADDR_WIDTH];
  assign head_data = head[DATA_WIDTH-1:0];
  assign head_imem = ({1'b0, head_addr} < ImemLimit);
  assign head_dmem = !head_imem && ({1'b0, head_addr} < DmemLimit);

  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    empty_load = 1'b0;
    cpu_hold   = (state_q != LdIdle);
    load_done  = (state_q == LdDone);
    unique case (state_q)
      LdIdle: begin
        if (in_valid) begin
          state_d    = LdLoad;
          start_load = 1'b1;
        end else if (in_done) begin
          state_d    = LdDone;
          empty_load = 1'b1;
        end
      end
      LdLoad:  if (in_done) state_d = LdDrain;
      // A word strobed this cycle is not yet visible in the FIFO, so it also blocks completion.
      LdDrain: if (fifo_empty && !strobe && !in_valid) state_d = LdDone;
      LdDone:  state_d = LdIdle;
      default: state_d = LdIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LdIdle;
      imem_we_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      dmem_addr_q <= '0;
      wdata_q     <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      rng_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      imem_we_q <= pop && head_imem;
      dmem_we_q <= pop && head_dmem;
      if (pop && head_imem) begin
        imem_addr_q <= head_addr;
        wdata_q     <= head_data;
      end
      if (pop && head_dmem) begin
        dmem_addr_q <= head_addr - DmemBase;
        wdata_q     <= head_data;
      end

      // A new load (or an empty program) restarts the accounting; clearing wins.
      if (start_load || empty_load) begin
        count_q <= '0;
        sum_q   <= '0;
      end else if (strobe) begin
        if (count_q != '1) count_q <= count_q + CountOne;
        sum_q <= sum_q + wdata_q;
      end

      if (start_load) begin
        ovf_q <= 1'b0;
        rng_q <= 1'b0;
      end else begin
        if (drop) ovf_q <= 1'b1;
        if (pop && !head_imem && !head_dmem) rng_q <= 1'b1;
      end
    end
  end

  assign imem_we      = imem_we_q;
  assign dmem_we      = dmem_we_q;
  assign imem_addr    = imem_addr_q;
  assign dmem_addr    = dmem_addr_q;
  assign mem_wdata    = wdata_q;
  assign word_count   = count_q;
  assign checksum     = sum_q;
  assign overflow_err = ovf_q;
  assign range_err    = rng_q;

endmodule
